// File: rtl/fb_arb_pkg.sv
// fb_arb_pkg: shared source ids and state encodings for the framebuffer write arbiter.
package fb_arb_pkg;
  localparam logic SRC_FIFO  = 1'b0;
  localparam logic SRC_BRUSH = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    STALL = 2'd2
  } fb_state_e;
endpackage

// File: rtl/rr2_burst_arbiter.sv
// rr2_burst_arbiter: 2-way round-robin grant between FIFO and brush with a contended-burst limit.
module rr2_burst_arbiter
  import fb_arb_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic req_fifo,
  input  logic req_brush,
  input  logic load_ok,
  input  logic owner,
  output logic gnt_fifo,
  output logic gnt_brush
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  logic [CW-1:0] burst_cnt;
  logic          both;
  logic          keep;
  logic          pick;
  logic          grant;

  always_comb begin
    both = req_fifo & req_brush;
    // a zero count means the owner has no live contended burst, so a tie alternates
    keep = (burst_cnt != '0) && (burst_cnt < BURST_MAX);
    if (both) pick = keep ? owner : ~owner;
    else      pick = req_brush ? SRC_BRUSH : SRC_FIFO;
    grant     = load_ok & (req_fifo | req_brush);
    gnt_fifo  = grant & (pick == SRC_FIFO);
    gnt_brush = grant & (pick == SRC_BRUSH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt <= '0;
    end else if (grant) begin
      if (pick != owner)
        burst_cnt <= both ? CW'(1) : '0;
      else if (both && (burst_cnt < BURST_MAX))
        burst_cnt <= burst_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: owns the framebuffer port; display reads win, FIFO and brush share blanking writes.
// Optional FB_ARB_STALL_CNT_EN adds stall_cnt, counting write-stage stalls caused by clear_busy.
module fb_write_arbiter
  import fb_arb_pkg::*;
#(
  parameter int HPOS_WIDTH = 10,
  parameter int VPOS_WIDTH = 10,
  parameter int RGB_WIDTH  = 3,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  display_on,
  input  logic [HPOS_WIDTH-1:0] disp_hpos,
  input  logic [VPOS_WIDTH-1:0] disp_vpos,
  input  logic                  clear_busy,
  input  logic                  fifo_empty,
  input  logic [HPOS_WIDTH-1:0] fifo_hpos,
  input  logic [VPOS_WIDTH-1:0] fifo_vpos,
  input  logic [RGB_WIDTH-1:0]  fifo_rgb,
  output logic                  fifo_pop,
  input  logic                  br_req,
  input  logic [HPOS_WIDTH-1:0] br_hpos,
  input  logic [VPOS_WIDTH-1:0] br_vpos,
  input  logic [RGB_WIDTH-1:0]  br_rgb,
  output logic                  br_ack,
  output logic [HPOS_WIDTH-1:0] fb_hpos,
  output logic [VPOS_WIDTH-1:0] fb_vpos,
  output logic [RGB_WIDTH-1:0]  fb_rgb,
  output logic                  fb_we
`ifdef FB_ARB_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);
  // state | meaning
  // IDLE  | write stage empty
  // WRITE | pixel held, retiring this cycle
  // STALL | pixel held, blocked by display_on or clear_busy
  fb_state_e             state;
  logic                  w_valid;
  logic                  w_src;
  logic [HPOS_WIDTH-1:0] w_hpos;
  logic [VPOS_WIDTH-1:0] w_vpos;
  logic [RGB_WIDTH-1:0]  w_rgb;
  logic                  retire;
  logic                  load_ok;
  logic                  load;
  logic                  gnt_fifo;
  logic                  gnt_brush;

  always_comb begin
    if (!w_valid)                      state = IDLE;
    else if (display_on || clear_busy) state = STALL;
    else                               state = WRITE;
  end

  assign retire  = (state == WRITE);
  assign load_ok = ~clear_busy & (~w_valid | retire);

  // w_src doubles as the last owner: it only changes on a load
  rr2_burst_arbiter #(.MAX_BURST(MAX_BURST)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_fifo  (~fifo_empty),
    .req_brush (br_req),
    .load_ok   (load_ok),
    .owner     (w_src),
    .gnt_fifo  (gnt_fifo),
    .gnt_brush (gnt_brush)
  );

  assign fifo_pop = gnt_fifo & ~reset;
  assign br_ack   = gnt_brush & ~reset;
  assign load     = fifo_pop | br_ack;
  assign fb_we    = retire;
  assign fb_hpos  = display_on ? disp_hpos : w_hpos;
  assign fb_vpos  = display_on ? disp_vpos : w_vpos;
  assign fb_rgb   = w_rgb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_valid <= 1'b0;
      w_src   <= SRC_BRUSH;
      w_hpos  <= '0;
      w_vpos  <= '0;
      w_rgb   <= '0;
    end else if (load) begin
      w_valid <= 1'b1;
      w_src   <= br_ack ? SRC_BRUSH : SRC_FIFO;
      w_hpos  <= br_ack ? br_hpos : fifo_hpos;
      w_vpos  <= br_ack ? br_vpos : fifo_vpos;
      w_rgb   <= br_ack ? br_rgb : fifo_rgb;
    end else if (retire) begin
      w_valid <= 1'b0;
    end
  end

`ifdef FB_ARB_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if ((state == STALL) && !display_on && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: vector table plus hand sequences; write data checked through a scoreboard queue.
module tb_fb_write_arbiter;
  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    bit   disp;
    bit   clr;
    bit   fpush;
    pix_t fp;
    bit   bpush;
    pix_t bp;
    bit   ep;
    bit   ea;
    bit   ew;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       display_on;
  logic [9:0] disp_hpos;
  logic [9:0] disp_vpos;
  logic       clear_busy;
  logic       fifo_empty;
  logic [9:0] fifo_hpos;
  logic [9:0] fifo_vpos;
  logic [2:0] fifo_rgb;
  logic       fifo_pop;
  logic       br_req;
  logic [9:0] br_hpos;
  logic [9:0] br_vpos;
  logic [2:0] br_rgb;
  logic       br_ack;
  logic [9:0] fb_hpos;
  logic [9:0] fb_vpos;
  logic [2:0] fb_rgb;
  logic       fb_we;
`ifdef FB_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  pix_t fifo_q[$];
  pix_t br_q[$];
  pix_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  fb_write_arbiter #(
    .HPOS_WIDTH(10), .VPOS_WIDTH(10), .RGB_WIDTH(3), .MAX_BURST(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .display_on (display_on),
    .disp_hpos  (disp_hpos),
    .disp_vpos  (disp_vpos),
    .clear_busy (clear_busy),
    .fifo_empty (fifo_empty),
    .fifo_hpos  (fifo_hpos),
    .fifo_vpos  (fifo_vpos),
    .fifo_rgb   (fifo_rgb),
    .fifo_pop   (fifo_pop),
    .br_req     (br_req),
    .br_hpos    (br_hpos),
    .br_vpos    (br_vpos),
    .br_rgb     (br_rgb),
    .br_ack     (br_ack),
    .fb_hpos    (fb_hpos),
    .fb_vpos    (fb_vpos),
    .fb_rgb     (fb_rgb),
    .fb_we      (fb_we)
`ifdef FB_ARB_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic pix_t mkpix(input int h, input int v, input int c);
    pix_t p;
    p.h = 10'(h);
    p.v = 10'(v);
    p.c = 3'(c);
    return p;
  endfunction

  function automatic vec_t mkv(input bit disp, input bit clr, input bit fpush, input pix_t fp,
                               input bit bpush, input pix_t bp, input bit ep, input bit ea,
                               input bit ew);
    vec_t r;
    r.disp = disp; r.clr = clr; r.fpush = fpush; r.fp = fp;
    r.bpush = bpush; r.bp = bp; r.ep = ep; r.ea = ea; r.ew = ew;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive_src();
    fifo_empty = (fifo_q.size() == 0);
    if (fifo_q.size() != 0) {fifo_hpos, fifo_vpos, fifo_rgb} = fifo_q[0];
    br_req = (br_q.size() != 0);
    if (br_q.size() != 0) {br_hpos, br_vpos, br_rgb} = br_q[0];
  endtask

  // Entered 1 time unit after a rising edge; samples mid-cycle, returns 1 unit after the next edge.
  task automatic cycle(input bit ep, input bit ea, input bit ew, input string tag);
    logic p;
    logic a;
    pix_t got;
    pix_t want;
    pix_t dummy;
    drive_src();
    disp_hpos = 10'((cyc * 7) % 640);
    disp_vpos = 10'(cyc % 480);
    #4;
    p = fifo_pop;
    a = br_ack;
    chk({tag, ":pop"}, 32'(p), 32'(ep));
    chk({tag, ":ack"}, 32'(a), 32'(ea));
    chk({tag, ":we"}, 32'(fb_we), 32'(ew));
    if (display_on) begin
      chk({tag, ":disp_h"}, 32'(fb_hpos), 32'(disp_hpos));
      chk({tag, ":disp_v"}, 32'(fb_vpos), 32'(disp_vpos));
    end
    if (fb_we) begin
      got = {fb_hpos, fb_vpos, fb_rgb};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s:wdata actual %0h required no write", tag, got);
      end else begin
        want = exp_q.pop_front();
        chk({tag, ":wdata"}, 32'(got), 32'(want));
      end
    end
    @(posedge clk);
    #1;
    if (p && fifo_q.size() != 0) dummy = fifo_q.pop_front();
    if (a && br_q.size() != 0) dummy = br_q.pop_front();
    cyc++;
  endtask

  initial begin
    vec_t tbl[$];
    pix_t z;
    pix_t pp;
    pix_t qq;
    pix_t rr;
    bit   seq[11];
    pix_t fpx[6];
    pix_t bpx[5];
    int   fi;
    int   bi;

    seq = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1};
    z = mkpix(0, 0, 0);
    // blanking burst from a 3-deep FIFO
    tbl.push_back(mkv(0, 0, 0, z, 0, z, 1, 0, 0));
    tbl.push_back(mkv(0, 0, 0, z, 0, z, 1, 0, 1));
    tbl.push_back(mkv(0, 0, 0, z, 0, z, 1, 0, 1));
    tbl.push_back(mkv(0, 0, 0, z, 0, z, 0, 0, 1));
    tbl.push_back(mkv(0, 0, 0, z, 0, z, 0, 0, 0));
    // prime during display, write on first blanking cycle
    tbl.push_back(mkv(1, 0, 1, mkpix(5, 7, 5), 0, z, 1, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mkv(1, 0, 0, z, 0, z, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0, z, 0, z, 0, 0, 1));
    tbl.push_back(mkv(0, 0, 0, z, 0, z, 0, 0, 0));
    // clear_busy holds a primed pixel for 10 cycles
    tbl.push_back(mkv(1, 0, 1, mkpix(9, 9, 6), 0, z, 1, 0, 0));
    tbl.push_back(mkv(0, 1, 1, mkpix(8, 8, 2), 0, z, 0, 0, 0));
    for (int i = 0; i < 9; i++) tbl.push_back(mkv(0, 1, 0, z, 0, z, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0, z, 0, z, 1, 0, 1));
    tbl.push_back(mkv(0, 0, 0, z, 0, z, 0, 0, 1));
    tbl.push_back(mkv(0, 0, 0, z, 0, z, 0, 0, 0));
    // brush alone, new data after each ack
    tbl.push_back(mkv(0, 0, 0, z, 1, mkpix(11, 12, 7), 0, 1, 0));
    tbl.push_back(mkv(0, 0, 0, z, 1, mkpix(13, 14, 1), 0, 1, 1));
    tbl.push_back(mkv(0, 0, 0, z, 1, mkpix(15, 16, 4), 0, 1, 1));
    tbl.push_back(mkv(0, 0, 0, z, 0, z, 0, 0, 1));
    tbl.push_back(mkv(0, 0, 0, z, 0, z, 0, 0, 0));

    reset = 1'b1; display_on = 1'b0; clear_busy = 1'b0;
    disp_hpos = '0; disp_vpos = '0;
    fifo_hpos = '0; fifo_vpos = '0; fifo_rgb = '0;
    br_hpos = '0; br_vpos = '0; br_rgb = '0;
    fifo_q.push_back(mkpix(30, 31, 7));
    br_q.push_back(mkpix(32, 33, 6));
    drive_src();
    #2;
    chk("reset:pop", 32'(fifo_pop), 32'(0));
    chk("reset:ack", 32'(br_ack), 32'(0));
    chk("reset:we", 32'(fb_we), 32'(0));
    fifo_q.delete();
    br_q.delete();
    drive_src();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(0, 0, 0, "idle");

    for (int k = 0; k < 3; k++) begin
      fifo_q.push_back(mkpix(1 + 2 * k, 2 + 2 * k, k + 1));
      exp_q.push_back(mkpix(1 + 2 * k, 2 + 2 * k, k + 1));
    end
    foreach (tbl[i]) begin
      display_on = tbl[i].disp;
      clear_busy = tbl[i].clr;
      if (tbl[i].fpush) begin fifo_q.push_back(tbl[i].fp); exp_q.push_back(tbl[i].fp); end
      if (tbl[i].bpush) begin br_q.push_back(tbl[i].bp); exp_q.push_back(tbl[i].bp); end
      cycle(tbl[i].ep, tbl[i].ea, tbl[i].ew, $sformatf("vec%0d", i));
    end
`ifdef FB_ARB_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(10));
`endif

    // both requesters contending, MAX_BURST=4
    display_on = 1'b0;
    clear_busy = 1'b0;
    for (int k = 0; k < 6; k++) begin fpx[k] = mkpix(100 + k, 200 + k, k); fifo_q.push_back(fpx[k]); end
    for (int k = 0; k < 5; k++) begin bpx[k] = mkpix(300 + k, 400 + k, 7 - k); br_q.push_back(bpx[k]); end
    fi = 0;
    bi = 0;
    for (int k = 0; k < 11; k++) begin
      if (seq[k]) begin exp_q.push_back(bpx[bi]); bi++; end
      else begin exp_q.push_back(fpx[fi]); fi++; end
    end
    for (int k = 0; k < 11; k++) cycle(!seq[k], seq[k], k != 0, $sformatf("rr%0d", k));
    cycle(0, 0, 1, "rr_tail");
    cycle(0, 0, 0, "rr_idle");

    // reset while a pixel sits in STALL
    pp = mkpix(20, 21, 3);
    qq = mkpix(22, 23, 4);
    rr = mkpix(24, 25, 5);
    display_on = 1'b1;
    fifo_q.push_back(pp);
    exp_q.push_back(pp);
    cycle(1, 0, 0, "rst_prime");
    fifo_q.push_back(qq);
    br_q.push_back(rr);
    cycle(0, 0, 0, "rst_stall");
    display_on = 1'b0;
    drive_src();
    reset = 1'b1;
    #2;
    chk("rst_async:we", 32'(fb_we), 32'(0));
    chk("rst_async:pop", 32'(fifo_pop), 32'(0));
    chk("rst_async:ack", 32'(br_ack), 32'(0));
`ifdef FB_ARB_STALL_CNT_EN
    chk("rst_async:stall_cnt", 32'(stall_cnt), 32'(0));
`endif
    exp_q.delete();
    exp_q.push_back(qq);
    exp_q.push_back(rr);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1, 0, 0, "rst_tie");
    cycle(0, 1, 1, "rst_brush");
    cycle(0, 0, 1, "rst_last");
    cycle(0, 0, 0, "rst_idle");

    chk("sb_empty", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
